// File: rtl/wb_pkg.sv
// Shared types and default sizing for the writeback stage.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    LS_B = 2'b00,
    LS_H = 2'b01,
    LS_W = 2'b10,
    LS_D = 2'b11
  } load_size_e;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF      = 32;

endpackage

// File: rtl/wb_load_extend.sv
// Sub-word load extraction with sign/zero extension and alignment check.
module wb_load_extend
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  rawData,
  input  logic [OFF_W-1:0] off,
  input  load_size_e       size,
  input  logic             isUnsigned,
  output logic [XLEN-1:0]  extData,
  output logic             misaligned
);

  logic [XLEN-1:0] shifted;

  // Shifting instead of indexed part-select keeps misaligned offsets in range.
  always_comb begin
    shifted    = rawData >> {off, 3'b000};
    extData    = '0;
    misaligned = 1'b0;
    unique case (size)
      LS_B: extData = isUnsigned ? XLEN'(shifted[7:0])
                                 : XLEN'($signed(shifted[7:0]));
      LS_H: begin
        misaligned = off[0];
        extData    = isUnsigned ? XLEN'(shifted[15:0])
                                : XLEN'($signed(shifted[15:0]));
      end
      LS_W: begin
        misaligned = |off[1:0];
        extData    = isUnsigned ? XLEN'(shifted[31:0])
                                : XLEN'($signed(shifted[31:0]));
      end
      LS_D: begin
        misaligned = (XLEN == 32) || (off != '0);
        extData    = shifted;
      end
      default: extData = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage_param.sv
// MEM/WB pipeline register, result select, regfile write gating and retire counter.
module writeback_stage_param
  import wb_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  localparam int unsigned OFF_W     = $clog2(XLEN / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_w,
  input  logic                  flush_w,
  input  logic                  valid_m,
  input  logic                  reg_write_m,
  input  logic [1:0]            result_src_m,
  input  logic [1:0]            load_size_m,
  input  logic                  load_unsigned_m,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [XLEN-1:0]       alu_result_m,
  input  logic [XLEN-1:0]       read_data_m,
  input  logic [XLEN-1:0]       pc_plus4_m,
  input  logic [XLEN-1:0]       imm_ext_m,
  output logic [XLEN-1:0]       result_w,
  output logic [REG_ADDR_W-1:0] rd_w,
  output logic                  reg_write_w,
  output logic                  valid_w,
  output logic                  misaligned_w,
  output logic [CNT_W-1:0]      retire_count
);

  logic [XLEN-1:0]       loadData;
  logic                  loadMis;
  logic [XLEN-1:0]       resultM;
  logic                  misM;

  logic                  validQ;
  logic                  regWriteQ;
  logic                  misQ;
  logic [REG_ADDR_W-1:0] rdQ;
  logic [XLEN-1:0]       resultQ;
  logic [CNT_W-1:0]      retireQ;

  wb_load_extend #(.XLEN(XLEN)) uLoadExtend (
    .rawData    (read_data_m),
    .off        (alu_result_m[OFF_W-1:0]),
    .size       (load_size_e'(load_size_m)),
    .isUnsigned (load_unsigned_m),
    .extData    (loadData),
    .misaligned (loadMis)
  );

  // Result selected before the register so W outputs depend only on flops.
  always_comb begin
    misM    = 1'b0;
    resultM = alu_result_m;
    unique case (result_src_e'(result_src_m))
      RES_ALU: resultM = alu_result_m;
      RES_MEM: begin
        misM    = loadMis;
        resultM = loadData;
      end
      RES_PC4: resultM = pc_plus4_m;
      RES_IMM: resultM = imm_ext_m;
      default: resultM = alu_result_m;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      validQ    <= 1'b0;
      regWriteQ <= 1'b0;
      misQ      <= 1'b0;
      rdQ       <= '0;
      resultQ   <= '0;
    end else if (flush_w) begin
      validQ    <= 1'b0;
      regWriteQ <= 1'b0;
      misQ      <= 1'b0;
    end else if (!stall_w) begin
      validQ    <= valid_m;
      regWriteQ <= reg_write_m;
      misQ      <= misM;
      rdQ       <= rd_m;
      resultQ   <= resultM;
    end
  end

  // A stalled instruction retires once, on the edge that releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      retireQ <= '0;
    end else if (validQ && !stall_w) begin
      retireQ <= retireQ + CNT_W'(1);
    end
  end

  assign result_w     = misQ ? '0 : resultQ;
  assign rd_w         = rdQ;
  assign valid_w      = validQ;
  assign misaligned_w = misQ;
  assign reg_write_w  = validQ & regWriteQ & ~misQ & (rdQ != '0);
  assign retire_count = retireQ;

endmodule

// File: tb/tb_writeback_stage_param.sv
// Scoreboard bench for writeback_stage_param at XLEN=32 and XLEN=64 (CNT_W=4).
module tb_writeback_stage_param;

  logic        clk = 1'b0;
  logic        rst32, rst64;
  logic        stall, flush, validM, regWriteM, loadUnsigned;
  logic [1:0]  src, size;
  logic [4:0]  rdM;
  logic [63:0] alu, rdata, pc4, imm;

  logic [31:0] result32;
  logic [4:0]  rd32;
  logic        rw32, valid32, mis32;
  logic [31:0] cnt32;

  logic [63:0] result64;
  logic [4:0]  rd64;
  logic        rw64, valid64, mis64;
  logic [3:0]  cnt64;

  always #5 clk = ~clk;

  writeback_stage_param dut32 (
    .clk(clk), .rst(rst32), .stall_w(stall), .flush_w(flush),
    .valid_m(validM), .reg_write_m(regWriteM), .result_src_m(src),
    .load_size_m(size), .load_unsigned_m(loadUnsigned), .rd_m(rdM),
    .alu_result_m(alu[31:0]), .read_data_m(rdata[31:0]),
    .pc_plus4_m(pc4[31:0]), .imm_ext_m(imm[31:0]),
    .result_w(result32), .rd_w(rd32), .reg_write_w(rw32),
    .valid_w(valid32), .misaligned_w(mis32), .retire_count(cnt32)
  );

  writeback_stage_param #(.XLEN(64), .CNT_W(4)) dut64 (
    .clk(clk), .rst(rst64), .stall_w(stall), .flush_w(flush),
    .valid_m(validM), .reg_write_m(regWriteM), .result_src_m(src),
    .load_size_m(size), .load_unsigned_m(loadUnsigned), .rd_m(rdM),
    .alu_result_m(alu), .read_data_m(rdata), .pc_plus4_m(pc4),
    .imm_ext_m(imm),
    .result_w(result64), .rd_w(rd64), .reg_write_w(rw64),
    .valid_w(valid64), .misaligned_w(mis64), .retire_count(cnt64)
  );

  typedef struct {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
    bit          chkData;
  } exp_t;

  exp_t        sb[$];
  int unsigned nVec = 0;
  int unsigned nBad = 0;
  int unsigned vecIdx = 0;
  logic        expValid = 1'b0;
  logic [31:0] expCnt = 32'd0;

  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // sel=0 exercises dut32 (dut64 held in reset), sel=1 the reverse.
  task automatic applyVec(input int sel, input int r, input int st, input int fl,
                          input int v, input int rw, input int s, input int sz,
                          input int u, input int rd, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] p,
                          input logic [63:0] i, input logic [63:0] eRes,
                          input int eRd, input int eRw, input int eMis,
                          input int chkData);
    exp_t e;
    string t;
    rst32        = (sel != 0) ? 1'b1 : (r != 0);
    rst64        = (sel != 0) ? (r != 0) : 1'b1;
    stall        = (st != 0);
    flush        = (fl != 0);
    validM       = (v != 0);
    regWriteM    = (rw != 0);
    src          = 2'(s);
    size         = 2'(sz);
    loadUnsigned = (u != 0);
    rdM          = 5'(rd);
    alu = a; rdata = d; pc4 = p; imm = i;
    if (r != 0) expCnt = 32'd0;
    else if (expValid && st == 0) expCnt = (sel != 0) ? ((expCnt + 32'd1) & 32'hF) : expCnt + 32'd1;
    if (r != 0 || fl != 0) expValid = 1'b0;
    else if (st == 0) expValid = (v != 0);
    e.result = eRes; e.rd = 5'(eRd); e.rw = (eRw != 0); e.valid = expValid;
    e.mis = (eMis != 0); e.cnt = expCnt; e.chkData = (chkData != 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vecIdx++;
    t = $sformatf("%s.v%0d", (sel != 0) ? "x64" : "x32", vecIdx);
    if (sel != 0) begin
      checkVal({t, ".valid"}, 64'(valid64), 64'(e.valid));
      checkVal({t, ".rw"}, 64'(rw64), 64'(e.rw));
      checkVal({t, ".cnt"}, 64'(cnt64), 64'(e.cnt));
      if (e.chkData) begin
        checkVal({t, ".res"}, result64, e.result);
        checkVal({t, ".rd"}, 64'(rd64), 64'(e.rd));
        checkVal({t, ".mis"}, 64'(mis64), 64'(e.mis));
      end
    end else begin
      checkVal({t, ".valid"}, 64'(valid32), 64'(e.valid));
      checkVal({t, ".rw"}, 64'(rw32), 64'(e.rw));
      checkVal({t, ".cnt"}, 64'(cnt32), 64'(e.cnt));
      if (e.chkData) begin
        checkVal({t, ".res"}, 64'(result32), e.result);
        checkVal({t, ".rd"}, 64'(rd32), 64'(e.rd));
        checkVal({t, ".mis"}, 64'(mis32), 64'(e.mis));
      end
    end
  endtask

  localparam logic [63:0] D32 = 64'h0000_0000_80FF_7F03;
  localparam logic [63:0] Z   = 64'h0;

  initial begin
    // XLEN=32: reset, ALU, loads, misaligned, stall/flush
    applyVec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z, Z, Z, Z, 0, 0, 0, 1);
    applyVec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z, Z, Z, Z, 0, 0, 0, 1);
    applyVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z, Z, Z, Z, 0, 0, 0, 1);
    applyVec(0, 0, 0, 0, 1, 1, 0, 0, 0, 5, 64'hF0, D32, Z, Z, 64'hF0, 5, 1, 0, 1);
    applyVec(0, 0, 0, 0, 1, 1, 1, 0, 0, 6, 64'h1003, D32, Z, Z, 64'hFFFF_FF80, 6, 1, 0, 1);
    applyVec(0, 0, 0, 0, 1, 1, 1, 0, 1, 7, 64'h1003, D32, Z, Z, 64'h0000_0080, 7, 1, 0, 1);
    applyVec(0, 0, 0, 0, 1, 1, 1, 1, 0, 8, 64'h1002, D32, Z, Z, 64'hFFFF_80FF, 8, 1, 0, 1);
    applyVec(0, 0, 0, 0, 1, 1, 1, 1, 1, 9, 64'h1002, D32, Z, Z, 64'h0000_80FF, 9, 1, 0, 1);
    applyVec(0, 0, 0, 0, 1, 1, 1, 2, 0, 10, 64'h1001, D32, Z, Z, Z, 10, 0, 1, 1);
    applyVec(0, 0, 0, 0, 1, 1, 1, 1, 0, 11, 64'h1003, D32, Z, Z, Z, 11, 0, 1, 1);
    applyVec(0, 0, 0, 0, 1, 1, 1, 3, 0, 12, 64'h1000, D32, Z, Z, Z, 12, 0, 1, 1);
    applyVec(0, 0, 0, 0, 1, 1, 1, 2, 0, 13, 64'h1000, D32, Z, Z, 64'h80FF_7F03, 13, 1, 0, 1);
    applyVec(0, 0, 0, 0, 1, 1, 2, 0, 0, 14, 64'h1000, D32, 64'h2004, Z, 64'h2004, 14, 1, 0, 1);
    for (int k = 0; k < 3; k++)
      applyVec(0, 0, 1, 0, 1, 1, 3, 0, 0, 15, Z, Z, Z, 64'h1234_5000, 64'h2004, 14, 1, 0, 1);
    applyVec(0, 0, 0, 0, 1, 1, 3, 0, 0, 15, Z, Z, Z, 64'h1234_5000, 64'h1234_5000, 15, 1, 0, 1);
    applyVec(0, 0, 1, 1, 1, 1, 0, 0, 0, 16, 64'h77, Z, Z, Z, Z, 0, 0, 0, 0);
    applyVec(0, 0, 0, 0, 1, 1, 2, 0, 0, 0, Z, Z, 64'h2004, Z, 64'h2004, 0, 0, 0, 1);
    applyVec(0, 0, 0, 1, 1, 1, 0, 0, 0, 17, 64'h55, Z, Z, Z, Z, 0, 0, 0, 0);
    applyVec(0, 1, 1, 0, 1, 1, 0, 0, 0, 18, 64'h99, Z, Z, Z, Z, 0, 0, 0, 1);
    applyVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z, Z, Z, Z, 0, 0, 0, 1);

    // XLEN=64, CNT_W=4: doubleword/word loads, misaligned double, counter wrap
    expValid = 1'b0;
    expCnt   = 32'd0;
    applyVec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z, Z, Z, Z, 0, 0, 0, 1);
    applyVec(1, 0, 0, 0, 1, 1, 1, 3, 0, 1, 64'h1000, 64'h8123_4567_89AB_CDEF, Z, Z,
             64'h8123_4567_89AB_CDEF, 1, 1, 0, 1);
    applyVec(1, 0, 0, 0, 1, 1, 1, 2, 1, 2, 64'h1000, 64'h0000_0000_FFFF_FFFF, Z, Z,
             64'h0000_0000_FFFF_FFFF, 2, 1, 0, 1);
    applyVec(1, 0, 0, 0, 1, 1, 1, 2, 0, 3, 64'h1004, 64'hFFFF_FFFF_0000_0000, Z, Z,
             64'hFFFF_FFFF_FFFF_FFFF, 3, 1, 0, 1);
    applyVec(1, 0, 0, 0, 1, 1, 1, 3, 0, 4, 64'h1004, 64'h8123_4567_89AB_CDEF, Z, Z,
             Z, 4, 0, 1, 1);
    applyVec(1, 0, 0, 0, 1, 1, 1, 0, 0, 5, 64'h1007, 64'h8123_4567_89AB_CDEF, Z, Z,
             64'hFFFF_FFFF_FFFF_FF81, 5, 1, 0, 1);
    applyVec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z, Z, Z, Z, 0, 0, 0, 1);
    for (int k = 0; k < 17; k++)
      applyVec(1, 0, 0, 0, 1, 1, 0, 0, 0, k + 1, 64'(k), Z, Z, Z, 64'(k), k + 1, 1, 0, 1);
    applyVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z, Z, Z, Z, 0, 0, 0, 1);
    checkVal("x64.wrap", 64'(cnt64), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
